// File: rtl/shift_reg_stim_seq_pkg.sv
// Shared constants for the shift-register stimulus sequencer: MODO encodings,
// FSM states, test count and the LFSR tap mask / step helper.
// Latency: n/a (package). Backpressure: n/a.
package shift_reg_stim_seq_pkg;

  // DUT mode encodings
  localparam logic [1:0] MODO_LOAD  = 2'b00;
  localparam logic [1:0] MODO_LEFT  = 2'b01;
  localparam logic [1:0] MODO_RIGHT = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  localparam logic [2:0] NUM_TESTS = 3'd5;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/shift_reg_golden.sv
// 4-bit reference shift register with serial-out: load / left / right / hold.
// Latency: Q and S_OUT update on the rising edge that samples the controls.
// Backpressure: none; i_enb=0 freezes state regardless of i_modo.
// Ports: i_clk, i_rst (async active-high), i_enb, i_modo[1:0], i_s_in, i_d[3:0],
//        o_q[3:0], o_s_out.
module shift_reg_golden
  import shift_reg_stim_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enb,
  input  logic [1:0] i_modo,
  input  logic       i_s_in,
  input  logic [3:0] i_d,
  output logic [3:0] o_q,
  output logic       o_s_out
);

  logic [3:0] r_q;
  logic       r_s_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q     <= 4'd0;
      r_s_out <= 1'b0;
    end else if (i_enb) begin
      case (i_modo)
        MODO_LOAD: begin
          r_q     <= i_d;
          r_s_out <= 1'b0;
        end
        MODO_LEFT: begin
          r_s_out <= r_q[3];
          r_q     <= {r_q[2:0], i_s_in};
        end
        MODO_RIGHT: begin
          r_s_out <= r_q[0];
          r_q     <= {i_s_in, r_q[3:1]};
        end
        default: ;
      endcase
    end
  end

  assign o_q     = r_q;
  assign o_s_out = r_s_out;

endmodule

// File: rtl/shift_reg_stim_seq.sv
// Stimulus sequencer: five fixed shift-register tests back to back, plus golden Q/S_OUT.
// Latency: all outputs registered; EXP_* reflect the stimulus consumed on the previous edge.
// Backpressure: none; START is only sampled in IDLE/DONE_ST, ignored mid-sequence.
// Ports: CLK, RESET (async active-high), START -> ENB, MODO[1:0], S_IN, D[3:0],
//        TEST_ID[2:0], EXP_Q[3:0], EXP_S_OUT, DONE.
// Build option: define LFSR_SIN_EN to drive S_IN from an 8-bit LFSR instead of CNT[0]^CNT[1].
module shift_reg_stim_seq
  import shift_reg_stim_seq_pkg::*;
#(
  parameter int         SHIFT_LEN = 8,
  parameter logic [3:0] SEED      = 4'b1011,
  parameter logic [7:0] LFSR_INIT = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  output logic       ENB,
  output logic [1:0] MODO,
  output logic       S_IN,
  output logic [3:0] D,
  output logic [2:0] TEST_ID,
  output logic [3:0] EXP_Q,
  output logic       EXP_S_OUT,
  output logic       DONE
);

  if (SHIFT_LEN < 2 || SHIFT_LEN > 255) begin : g_bad_len
    $error("shift_reg_stim_seq: SHIFT_LEN out of range 2..255");
  end
  if (LFSR_INIT == 8'h00) begin : g_bad_lfsr
    $error("shift_reg_stim_seq: LFSR_INIT must be nonzero");
  end

  localparam logic [7:0] LAST_CNT = 8'(SHIFT_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_test_id, w_test_nxt;
  logic       r_enb, w_enb_nxt;
  logic [1:0] r_modo, w_modo_nxt;
  logic       r_s_in, w_s_in_nxt;
  logic [3:0] r_d, w_d_nxt;
  logic       r_done, w_done_nxt;
  logic       w_run_sin;

`ifdef LFSR_SIN_EN
  logic [7:0] r_lfsr, w_lfsr_nxt;

  // Reload on every LOAD so each test sees the same stream; step once per RUN cycle.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (w_state_nxt == LOAD) begin
      w_lfsr_nxt = LFSR_INIT;
    end else if (r_state == RUN) begin
      w_lfsr_nxt = lfsr_step(r_lfsr);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_lfsr <= LFSR_INIT;
    else       r_lfsr <= w_lfsr_nxt;
  end

  assign w_run_sin = w_lfsr_nxt[0];
`else
  assign w_run_sin = w_cnt_nxt[0] ^ w_cnt_nxt[1];
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_test_id <= 3'd0;
      r_enb     <= 1'b0;
      r_modo    <= MODO_HOLD;
      r_s_in    <= 1'b0;
      r_d       <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_test_id <= w_test_nxt;
      r_enb     <= w_enb_nxt;
      r_modo    <= w_modo_nxt;
      r_s_in    <= w_s_in_nxt;
      r_d       <= w_d_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_test_nxt  = r_test_id;
    case (r_state)
      IDLE, DONE_ST: begin
        if (START) begin
          w_state_nxt = LOAD;
          w_test_nxt  = 3'd1;
        end
      end
      LOAD: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 8'd0;
      end
      RUN: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == LAST_CNT) begin
          if (r_test_id < NUM_TESTS) begin
            w_state_nxt = LOAD;
            w_test_nxt  = r_test_id + 3'd1;
          end else begin
            w_state_nxt = DONE_ST;
            w_test_nxt  = 3'd0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they are valid the cycle that state is entered.
    w_enb_nxt  = 1'b0;
    w_modo_nxt = MODO_HOLD;
    w_s_in_nxt = 1'b0;
    w_d_nxt    = 4'd0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      LOAD: begin
        w_enb_nxt  = 1'b1;
        w_modo_nxt = MODO_LOAD;
        w_d_nxt    = SEED;
      end
      RUN: begin
        w_enb_nxt  = 1'b1;
        w_d_nxt    = SEED;
        w_s_in_nxt = w_run_sin;
        case (w_test_nxt)
          3'd1: w_modo_nxt = MODO_HOLD;
          3'd2: w_modo_nxt = MODO_LEFT;
          3'd3: w_modo_nxt = MODO_RIGHT;
          3'd4: w_modo_nxt = w_cnt_nxt[0] ? MODO_RIGHT : MODO_LEFT;
          default: begin
            w_modo_nxt = MODO_LEFT;
            w_enb_nxt  = ~w_cnt_nxt[0];
          end
        endcase
      end
      DONE_ST: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Golden register consumes the registered stimulus on the same edge a DUT would.
  shift_reg_golden u_golden (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_enb   (r_enb),
    .i_modo  (r_modo),
    .i_s_in  (r_s_in),
    .i_d     (r_d),
    .o_q     (EXP_Q),
    .o_s_out (EXP_S_OUT)
  );

  assign ENB     = r_enb;
  assign MODO    = r_modo;
  assign S_IN    = r_s_in;
  assign D       = r_d;
  assign TEST_ID = r_test_id;
  assign DONE    = r_done;

endmodule

// File: tb/tb_shift_reg_stim_seq.sv
// Directed bench for shift_reg_stim_seq (default build, SHIFT_LEN=8, SEED=1011).
// Edge k counts rising edges after the edge that enters the first LOAD (k=0).
module tb_shift_reg_stim_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic       ENB;
  logic [1:0] MODO;
  logic       S_IN;
  logic [3:0] D;
  logic [2:0] TEST_ID;
  logic [3:0] EXP_Q;
  logic       EXP_S_OUT;
  logic       DONE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  shift_reg_stim_seq #(
    .SHIFT_LEN (8),
    .SEED      (4'b1011),
    .LFSR_INIT (8'hA5)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ENB       (ENB),
    .MODO      (MODO),
    .S_IN      (S_IN),
    .D         (D),
    .TEST_ID   (TEST_ID),
    .EXP_Q     (EXP_Q),
    .EXP_S_OUT (EXP_S_OUT),
    .DONE      (DONE)
  );

  // Hand-computed tables
  logic [3:0] t2_q   [4] = '{4'b0110, 4'b1101, 4'b1011, 4'b0110};  // after edges 11..14
  logic       t2_so  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic       t2_sin [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // after edges 10..17
  logic [3:0] t5_q   [7] = '{4'b0110, 4'b0110, 4'b1101, 4'b1101, 4'b1010, 4'b1010, 4'b0101}; // edges 38..44
  logic       t5_so  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Launches from IDLE/DONE_ST with START already high and checks all 45 following edges.
  task automatic run_sequence(input bit hold_start, input string run);
    tick();
    if (!hold_start) START = 1'b0;
    check({run, " load0 test_id"}, 32'(TEST_ID), 32'd1);
    check({run, " load0 modo"}, 32'(MODO), 32'd0);
    check({run, " load0 enb"}, 32'(ENB), 32'd1);
    check({run, " load0 d"}, 32'(D), 32'b1011);
    check({run, " load0 done"}, 32'(DONE), 32'd0);
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k < 45) begin
        check($sformatf("%s k%0d test_id", run, k), 32'(TEST_ID), 32'(k / 9 + 1));
        check($sformatf("%s k%0d done", run, k), 32'(DONE), 32'd0);
        if (k % 9 == 0)
          check($sformatf("%s k%0d load modo", run, k), 32'(MODO), 32'd0);
      end else begin
        check({run, " done rise"}, 32'(DONE), 32'd1);
        check({run, " done test_id"}, 32'(TEST_ID), 32'd0);
        check({run, " done enb"}, 32'(ENB), 32'd0);
        check({run, " done modo"}, 32'(MODO), 32'd3);
        check({run, " done exp_q"}, 32'(EXP_Q), 32'b0101);
        check({run, " done exp_s_out"}, 32'(EXP_S_OUT), 32'd1);
      end
      if (k >= 1 && k <= 8) begin
        check($sformatf("%s t1 k%0d exp_q", run, k), 32'(EXP_Q), 32'b1011);
        check($sformatf("%s t1 k%0d s_out", run, k), 32'(EXP_S_OUT), 32'd0);
        check($sformatf("%s t1 k%0d modo", run, k), 32'(MODO), 32'd3);
      end
      if (k >= 10 && k <= 17) begin
        check($sformatf("%s t2 k%0d s_in", run, k), 32'(S_IN), 32'(t2_sin[k-10]));
        check($sformatf("%s t2 k%0d modo", run, k), 32'(MODO), 32'd1);
      end
      if (k >= 11 && k <= 14) begin
        check($sformatf("%s t2 k%0d exp_q", run, k), 32'(EXP_Q), 32'(t2_q[k-11]));
        check($sformatf("%s t2 k%0d s_out", run, k), 32'(EXP_S_OUT), 32'(t2_so[k-11]));
      end
      if (k >= 19 && k <= 26)
        check($sformatf("%s t3 k%0d modo", run, k), 32'(MODO), 32'd2);
      if (k == 20) begin
        check({run, " t3 k20 exp_q"}, 32'(EXP_Q), 32'b0101);
        check({run, " t3 k20 s_out"}, 32'(EXP_S_OUT), 32'd1);
      end
      if (k == 21) begin
        check({run, " t3 k21 exp_q"}, 32'(EXP_Q), 32'b1010);
        check({run, " t3 k21 s_out"}, 32'(EXP_S_OUT), 32'd1);
      end
      if (k >= 28 && k <= 35)
        check($sformatf("%s t4 k%0d modo", run, k), 32'(MODO), ((k - 28) % 2 == 1) ? 32'd2 : 32'd1);
      if (k >= 37 && k <= 44) begin
        check($sformatf("%s t5 k%0d enb", run, k), 32'(ENB), ((k - 37) % 2 == 1) ? 32'd0 : 32'd1);
        check($sformatf("%s t5 k%0d modo", run, k), 32'(MODO), 32'd1);
      end
      if (k >= 38 && k <= 44) begin
        check($sformatf("%s t5 k%0d exp_q", run, k), 32'(EXP_Q), 32'(t5_q[k-38]));
        check($sformatf("%s t5 k%0d s_out", run, k), 32'(EXP_S_OUT), 32'(t5_so[k-38]));
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    #12;
    check("rst test_id", 32'(TEST_ID), 32'd0);
    check("rst enb", 32'(ENB), 32'd0);
    check("rst modo", 32'(MODO), 32'd3);
    check("rst s_in", 32'(S_IN), 32'd0);
    check("rst d", 32'(D), 32'd0);
    check("rst exp_q", 32'(EXP_Q), 32'd0);
    check("rst exp_s_out", 32'(EXP_S_OUT), 32'd0);
    check("rst done", 32'(DONE), 32'd0);

    @(negedge CLK);
    RESET = 1'b0;
    tick();
    tick();
    check("idle test_id", 32'(TEST_ID), 32'd0);
    check("idle enb", 32'(ENB), 32'd0);

    // Run 1: single START pulse
    START = 1'b1;
    run_sequence(1'b0, "run1");
    tick();
    tick();
    check("done hold done", 32'(DONE), 32'd1);
    check("done hold test_id", 32'(TEST_ID), 32'd0);
    check("done hold exp_q", 32'(EXP_Q), 32'b0101);

    // Run 2: START held high throughout, including into DONE_ST
    START = 1'b1;
    run_sequence(1'b1, "run2");
    tick();
    check("restart done low", 32'(DONE), 32'd0);
    check("restart test_id", 32'(TEST_ID), 32'd1);
    check("restart modo", 32'(MODO), 32'd0);

    // Run 3 started by held START; abort with reset in test 3 RUN (edge 21)
    for (int i = 0; i < 21; i++) tick();
    check("pre-abort test_id", 32'(TEST_ID), 32'd3);
    #2;
    RESET = 1'b1;
    START = 1'b0;
    #1;
    check("abort test_id", 32'(TEST_ID), 32'd0);
    check("abort exp_q", 32'(EXP_Q), 32'd0);
    check("abort enb", 32'(ENB), 32'd0);
    check("abort modo", 32'(MODO), 32'd3);
    check("abort done", 32'(DONE), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post-abort test_id", 32'(TEST_ID), 32'd0);
    check("post-abort enb", 32'(ENB), 32'd0);
    check("post-abort exp_q", 32'(EXP_Q), 32'd0);
    check("post-abort done", 32'(DONE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_stim_seq.md
Name: shift_reg_stim_seq

Overview:
- Clocked stimulus sequencer feeding both 4-bit shift register implementations (behavioural and structural) directly upstream of the Q/S_OUT comparison stage.
- Runs five fixed test phases (tests 1-5) back to back and drives identical control and data to both DUT copies.
- Carries a registered golden model, so EXP_Q/EXP_S_OUT line up cycle-for-cycle with a correct DUT.

Parameters:
SHIFT_LEN, 8, shift cycles per test after the initial load cycle (legal 2..255)
SEED, 4'b1011, parallel-load value used at the start of every test
LFSR_INIT, 8'hA5, nonzero LFSR reset value (used only with LFSR_SIN_EN)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  level; sampled in IDLE or DONE_ST to launch the sequence
ENB  output  1  DUT enable; 0 = DUT holds regardless of MODO
MODO  output  2  DUT mode: 00 load D, 01 shift left, 10 shift right, 11 hold
S_IN  output  1  serial input bit to DUT
D  output  4  parallel load data
TEST_ID  output  3  active test 1..5; 0 when idle
EXP_Q  output  4  golden Q after the current edge
EXP_S_OUT  output  1  golden serial-out after the current edge
DONE  output  1  high while in DONE_ST

Behaviour:
- Reset (async, immediate): state IDLE, CNT=0, TEST_ID=0, ENB=0, MODO=11, S_IN=0, D=0, EXP_Q=0, EXP_S_OUT=0, DONE=0, LFSR=LFSR_INIT. Reset mid-test aborts with no partial completion.
- FSM states: IDLE, LOAD, RUN, DONE_ST.
  - IDLE --START--> LOAD with TEST_ID=1.
  - LOAD (1 cycle: ENB=1, MODO=00, D=SEED) --> RUN with CNT=0.
  - RUN: CNT increments each cycle. At CNT==SHIFT_LEN-1:
    - TEST_ID<5: TEST_ID+1, go to LOAD.
    - TEST_ID==5: go to DONE_ST.
  - DONE_ST: DONE=1, TEST_ID=0, ENB=0, MODO=11. START --> LOAD with TEST_ID=1; otherwise hold.
- Total sequence length: 5*(1+SHIFT_LEN) cycles from the first LOAD to DONE.
- Outputs are registered and change on the edge entering a state/cycle. The DUT samples them on the following edge.
- RUN stimulus per test:
  - Test 1: ENB=1, MODO=11 (hold); Q stays SEED.
  - Test 2: ENB=1, MODO=01.
  - Test 3: ENB=1, MODO=10.
  - Test 4: ENB=1, MODO=01 when CNT[0]=0, else 10.
  - Test 5: MODO=01, ENB=~CNT[0].
- S_IN fixed pattern: CNT[0]^CNT[1].
- Golden model: updates EXP_Q/EXP_S_OUT on the same edge the DUT consumes the stimulus.
  - Load: EXP_Q=D, EXP_S_OUT=0.
  - Left: EXP_S_OUT=EXP_Q[3], EXP_Q={EXP_Q[2:0],S_IN}.
  - Right: EXP_S_OUT=EXP_Q[0], EXP_Q={S_IN,EXP_Q[3:1]}.
  - Hold or ENB=0: both unchanged.
- START deasserted mid-run has no effect. START held high in DONE_ST restarts immediately.
- CNT width is 8 bits; it never wraps because it is cleared on each LOAD.

Optional Feature:
- Macro LFSR_SIN_EN.
- Defined: S_IN=LFSR[0]. The 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every RUN cycle and is reloaded to LFSR_INIT on each LOAD, so every test sees the same sequence.
- Undefined: no LFSR logic; S_IN uses the fixed CNT pattern.

Decomposition:
- Shared package holds:
  - MODO encodings (MODO_LOAD, MODO_LEFT, MODO_RIGHT, MODO_HOLD).
  - FSM state constants.
  - NUM_TESTS=5.
  - LFSR tap constant.
- One sub-module, shift_reg_golden: the 4-bit golden register with S_OUT, taking ENB/MODO/S_IN/D, reset async to 0. It is reused later as a DUT reference.

Test Plan:
- RESET asserted mid-RUN of test 3 -> same cycle: TEST_ID=0, EXP_Q=0, ENB=0, MODO=11. After release the block stays in IDLE until START.
- START pulse, SHIFT_LEN=8 -> TEST_ID steps 1..5 with 9 cycles each. DONE rises exactly 45 cycles after the first LOAD edge.
- Test 1 -> EXP_Q=1011 for all 8 RUN cycles, EXP_S_OUT=0.
- Test 2, fixed S_IN -> S_IN sequence 0,1,1,0 repeating; EXP_Q after 4 shifts = 0110; EXP_S_OUT sequence 1,0,1,1.
- Test 5 -> EXP_Q changes only on edges after CNT odd→ENB... with ENB=1 on even CNT; EXP_Q constant across every ENB=0 cycle.
- With LFSR_SIN_EN -> identical S_IN stream in tests 2 and 3. Without the macro -> S_IN equals CNT[0]^CNT[1]. START held high -> DONE high exactly 1 cycle, then LOAD with TEST_ID=1.
